// File: rtl/fp_div_iter_pkg.sv
// Shared types and constants for the iterative FP divider and its rounder hand-off.
// Used by fp_div_iter (optional build macro there: FP_DIV_EARLY_EXIT_EN).
package fp_wire;

   localparam int MANT_W = 54;
   localparam int EXPO_W = 14;
   localparam int REM_W  = MANT_W + 1;
   localparam int CNT_W  = 7;

   localparam int BIAS_S = 127;
   localparam int BIAS_D = 1023;
   localparam int PREC_S = 24;
   localparam int PREC_D = 53;
   localparam int ITER_S = 26;
   localparam int ITER_D = 55;

   typedef struct packed {
      logic snan;
      logic qnan;
      logic inf;
      logic zero;
   } fp_class_type;

   typedef struct packed {
      logic                     a_sig;
      logic signed [EXPO_W-1:0] a_expo;
      logic [MANT_W-2:0]        a_mant;
      fp_class_type             a_class;
      logic                     b_sig;
      logic signed [EXPO_W-1:0] b_expo;
      logic [MANT_W-2:0]        b_mant;
      fp_class_type             b_class;
      logic [1:0]               fmt;
      logic [2:0]               rm;
   } fp_div_iter_in_type;

   typedef struct packed {
      logic                     sig;
      logic signed [EXPO_W-1:0] expo;
      logic [MANT_W-1:0]        mant;
      logic [1:0]               rema;
      logic [1:0]               fmt;
      logic [2:0]               rm;
      logic [2:0]               grs;
      logic                     snan;
      logic                     qnan;
      logic                     dbz;
      logic                     infs;
      logic                     zero;
      logic                     diff;
   } fp_rnd_in_type;

   typedef enum logic [1:0] {IDLE, DIV, DENORM, DONE} fp_div_state_type;

   // Special-case flags {snan, qnan, dbz, infs, zero}; all zero means a normal divide.
   function automatic logic [4:0] div_special_flags(input fp_div_iter_in_type d);
      logic [4:0] f;
      f = '0;
      if (d.a_class.snan || d.b_class.snan)
         f = 5'b10000;
      else if (d.a_class.qnan || d.b_class.qnan)
         f = 5'b01000;
      else if ((d.a_class.inf && d.b_class.inf) || (d.a_class.zero && d.b_class.zero))
         f = 5'b10000;
      else if (d.b_class.zero && !d.a_class.inf)
         f = 5'b00100;
      else if (d.a_class.inf)
         f = 5'b00010;
      else if (d.b_class.inf || d.a_class.zero)
         f = 5'b00001;
      return f;
   endfunction

endpackage

// File: rtl/fp_div_step.sv
// One restoring division step: compare, conditionally subtract, shift left.
module fp_div_step
   import fp_wire::*;
(
   input  logic [REM_W-1:0] rem_i,
   input  logic [REM_W-1:0] div_i,
   output logic [REM_W-1:0] rem_o,
   output logic             q_bit_o
);

   logic [REM_W-1:0] part;

   always_comb begin
      q_bit_o = (rem_i >= div_i);
      part    = q_bit_o ? (rem_i - div_i) : rem_i;
      rem_o   = part << 1;
   end

endmodule

// File: rtl/fp_div_iter.sv
// Iterative radix-2 restoring mantissa divider producing one rounder record per FDIV.
// Build option FP_DIV_EARLY_EXIT_EN: stop iterating once the partial remainder is zero.
module fp_div_iter
   import fp_wire::*;
(
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic               kill,
   input  fp_div_iter_in_type div_i,
   output logic               ready,
   output logic               valid,
   output fp_rnd_in_type      rnd_o
);

   localparam logic signed [EXPO_W-1:0] EXP_ONE = EXPO_W'(1);

   fp_div_state_type state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   fp_rnd_in_type    out_q, out_d;
   fp_rnd_in_type    wk_q, wk_d;
   logic [REM_W-1:0] rem_q, rem_d;
   logic [REM_W-1:0] dvs_q, dvs_d;
   logic [REM_W-1:0] quo_q, quo_d;

   logic [REM_W-1:0] step_rem;
   logic             step_q;
   logic [REM_W-1:0] q_bit_vec;
   logic [REM_W-1:0] ma, mb;
   logic [4:0]       spec;
   logic             dp_in, dp_wk, rem_nz, last_it;
   logic signed [EXPO_W-1:0] expo_set, den_n, den_cap;

   fp_div_step u_step (
      .rem_i   (rem_q),
      .div_i   (dvs_q),
      .rem_o   (step_rem),
      .q_bit_o (step_q)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      wk_d    = wk_q;
      rem_d   = rem_q;
      dvs_d   = dvs_q;
      quo_d   = quo_q;
      last_it = 1'b0;

      spec     = div_special_flags(div_i);
      dp_in    = (div_i.fmt != 2'd0);
      dp_wk    = (wk_q.fmt != 2'd0);
      ma       = REM_W'(div_i.a_mant);
      mb       = REM_W'(div_i.b_mant);
      expo_set = div_i.a_expo - div_i.b_expo + (dp_in ? EXPO_W'(BIAS_D) : EXPO_W'(BIAS_S));
      // Pre-shift the dividend so the quotient always lands in [1,2).
      if (ma < mb) begin
         ma       = ma << 1;
         expo_set = expo_set - EXP_ONE;
      end

      rem_nz    = (step_rem != '0);
      q_bit_vec = REM_W'(step_q) << (cnt_q - 1'b1);
      den_n     = EXP_ONE - wk_q.expo;
      den_cap   = dp_wk ? EXPO_W'(PREC_D + 3) : EXPO_W'(PREC_S + 3);

      case (state_q)
         IDLE: begin
            if (start && !kill) begin
               if (spec != '0) begin
                  out_d     = '0;
                  out_d.sig = div_i.a_sig ^ div_i.b_sig;
                  out_d.fmt = div_i.fmt;
                  out_d.rm  = div_i.rm;
                  {out_d.snan, out_d.qnan, out_d.dbz, out_d.infs, out_d.zero} = spec;
                  state_d   = DONE;
               end else begin
                  wk_d      = '0;
                  wk_d.sig  = div_i.a_sig ^ div_i.b_sig;
                  wk_d.expo = expo_set;
                  wk_d.fmt  = div_i.fmt;
                  wk_d.rm   = div_i.rm;
                  rem_d     = ma;
                  dvs_d     = mb;
                  quo_d     = '0;
                  cnt_d     = dp_in ? CNT_W'(ITER_D) : CNT_W'(ITER_S);
                  state_d   = DIV;
               end
            end
         end

         DIV: begin
            if (kill) begin
               state_d = IDLE;
            end else begin
               rem_d   = step_rem;
               quo_d   = quo_q | q_bit_vec;
               cnt_d   = cnt_q - 1'b1;
               last_it = (cnt_q == CNT_W'(1));
`ifdef FP_DIV_EARLY_EXIT_EN
               if (!rem_nz) last_it = 1'b1;
`endif
               if (last_it) begin
                  wk_d.mant = MANT_W'(quo_d >> 2);
                  wk_d.grs  = {quo_d[1], quo_d[0], rem_nz};
                  wk_d.rema = {1'b0, rem_nz};
                  if (wk_q.expo < EXP_ONE) begin
                     cnt_d   = (den_n > den_cap) ? CNT_W'(den_cap) : CNT_W'(den_n);
                     state_d = DENORM;
                  end else begin
                     out_d   = wk_d;
                     state_d = DONE;
                  end
               end
            end
         end

         DENORM: begin
            if (kill) begin
               state_d = IDLE;
            end else begin
               wk_d.mant = wk_q.mant >> 1;
               wk_d.grs  = {wk_q.mant[0], wk_q.grs[2], wk_q.grs[1] | wk_q.grs[0]};
               wk_d.expo = wk_q.expo + EXP_ONE;
               cnt_d     = cnt_q - 1'b1;
               // Once the shift budget is spent the exponent is encoded as subnormal.
               if (cnt_q == CNT_W'(1)) begin
                  wk_d.expo = '0;
                  out_d     = wk_d;
                  state_d   = DONE;
               end
            end
         end

         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
      end
   end

   always_ff @(posedge clock) begin
      wk_q  <= wk_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      quo_q <= quo_d;
   end

   assign ready = (state_q == IDLE);
   assign valid = (state_q == DONE);
   assign rnd_o = out_q;

endmodule

// File: tb/tb_fp_div_iter.sv
// Self-checking bench for fp_div_iter: behavioural long-division model, directed and random operations.
module tb_fp_div_iter;
   import fp_wire::*;

   logic               clock = 1'b0;
   logic               reset, start, kill;
   fp_div_iter_in_type div_i;
   logic               ready, valid;
   fp_rnd_in_type      rnd_o;

   fp_div_iter dut (
      .clock (clock),
      .reset (reset),
      .start (start),
      .kill  (kill),
      .div_i (div_i),
      .ready (ready),
      .valid (valid),
      .rnd_o (rnd_o)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int            checks = 0, errors = 0;
   bit            chk_en = 1'b0, pend = 1'b0;
   int            due = 0, start_cyc = 0;
   fp_rnd_in_type exp_rec = '0, last_rec = '0;

`ifdef FP_DIV_EARLY_EXIT_EN
   localparam int LAT_62 = 3;
   localparam int LAT_MIN = 3;
`else
   localparam int LAT_62 = 27;
   localparam int LAT_MIN = 57;
`endif

   // Reference: exact long division on wide integers, then denormalising shift.
   function automatic void model(input fp_div_iter_in_type d, output fp_rnd_in_type r, output int lat);
      bit dp, s;
      int p, q, e, k, n;
      logic [127:0] ma, mb, num, quo, rem, chain;
      fp_class_type a, b;
      a = d.a_class; b = d.b_class;
      dp = (d.fmt != 2'd0);
      p = dp ? 53 : 24;
      q = p + 2;
      r = '0;
      r.sig = d.a_sig ^ d.b_sig;
      r.fmt = d.fmt;
      r.rm  = d.rm;
      lat = 1;
      if (a.snan || b.snan) r.snan = 1'b1;
      else if (a.qnan || b.qnan) r.qnan = 1'b1;
      else if ((a.inf && b.inf) || (a.zero && b.zero)) r.snan = 1'b1;
      else if (b.zero && !a.inf) r.dbz = 1'b1;
      else if (a.inf) r.infs = 1'b1;
      else if (b.inf || a.zero) r.zero = 1'b1;
      else begin
         e  = int'(d.a_expo) - int'(d.b_expo) + (dp ? 1023 : 127);
         ma = 128'(d.a_mant);
         mb = 128'(d.b_mant);
         if (ma < mb) begin ma = ma * 2; e = e - 1; end
         num = ma << (q - 1);
         quo = num / mb;
         rem = num % mb;
         k = q;
`ifdef FP_DIV_EARLY_EXIT_EN
         for (int i = q; i >= 1; i--)
            if (((ma << (i - 1)) % mb) == 0) k = i;
`endif
         s = (rem != 0);
         r.rema = {1'b0, s};
         lat = k + 1;
         chain = quo;
         if (e <= 0) begin
            n = 1 - e;
            lat += (n < p + 3) ? n : p + 3;
            if (n >= q) begin
               s = s | (chain != 0);
               chain = '0;
            end else begin
               s = s | ((chain & ((128'd1 << n) - 1)) != 0);
               chain = chain >> n;
            end
            e = 0;
         end
         r.expo = EXPO_W'(e);
         r.mant = MANT_W'(chain >> 2);
         r.grs  = {chain[1], chain[0], s};
      end
   endfunction

   function automatic fp_div_iter_in_type mk(input logic sa, input int ea, input logic [52:0] ma,
                                             input logic [3:0] ca, input logic sb, input int eb,
                                             input logic [52:0] mb, input logic [3:0] cb,
                                             input logic [1:0] f, input logic [2:0] rmv);
      fp_div_iter_in_type d;
      d.a_sig = sa; d.a_expo = EXPO_W'(ea); d.a_mant = ma; d.a_class = fp_class_type'(ca);
      d.b_sig = sb; d.b_expo = EXPO_W'(eb); d.b_mant = mb; d.b_class = fp_class_type'(cb);
      d.fmt = f; d.rm = rmv;
      return d;
   endfunction

   function automatic fp_rnd_in_type mkr(input logic sg, input int e, input logic [MANT_W-1:0] m,
                                         input logic [2:0] g, input logic [1:0] ra,
                                         input logic [4:0] fl, input logic [1:0] f,
                                         input logic [2:0] rmv);
      fp_rnd_in_type r;
      r = '0;
      r.sig = sg; r.expo = EXPO_W'(e); r.mant = m; r.grs = g; r.rema = ra;
      {r.snan, r.qnan, r.dbz, r.infs, r.zero} = fl;
      r.fmt = f; r.rm = rmv;
      return r;
   endfunction

   function automatic logic [52:0] rand_mant(input bit dp);
      logic [63:0] x;
      x = {$urandom, $urandom};
      if ($urandom_range(3) == 0) x = x & (x >> 9) & (x >> 17);
      if ($urandom_range(4) == 0) x = '0;
      return dp ? {1'b1, x[51:0]} : {29'b0, 1'b1, x[22:0]};
   endfunction

   function automatic logic [3:0] rand_class();
      int c;
      c = int'($urandom_range(19));
      if (c == 0) return 4'b1000;
      if (c == 1) return 4'b0100;
      if (c <= 3) return 4'b0010;
      if (c <= 5) return 4'b0001;
      return 4'b0000;
   endfunction

   function automatic fp_div_iter_in_type rand_op();
      logic [1:0] f;
      int bias, ea, eb;
      bit dp;
      f = ($urandom_range(9) == 0) ? 2'($urandom_range(3, 2)) : 2'($urandom_range(1));
      dp = (f != 2'd0);
      bias = dp ? 1023 : 127;
      if ($urandom_range(2) == 0) begin
         ea = int'($urandom_range(40));
         eb = ea + bias + int'($urandom_range(100)) - 20;
      end else begin
         ea = int'($urandom_range(2 * bias));
         eb = int'($urandom_range(2 * bias));
      end
      return mk(1'($urandom), ea, rand_mant(dp), rand_class(),
                1'($urandom), eb, rand_mant(dp), rand_class(), f, 3'($urandom));
   endfunction

   // Compare process: valid/ready every cycle, full record on the valid cycle, hold otherwise.
   always @(negedge clock) begin
      if (chk_en) begin
         automatic bit ev = pend && (cyc == due);
         automatic bit rdy = !(pend && (cyc > start_cyc));
         checks++;
         if (valid !== ev) begin
            errors++;
            $display("FAIL valid cyc=%0d got=%b exp=%b", cyc, valid, ev);
         end
         checks++;
         if (ready !== rdy) begin
            errors++;
            $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, ready, rdy);
         end
         checks++;
         if (ev) begin
            if (rnd_o !== exp_rec) begin
               errors++;
               $display("FAIL result cyc=%0d got=%h exp=%h", cyc, rnd_o, exp_rec);
            end
            last_rec = exp_rec;
            pend = 1'b0;
         end else if (rnd_o !== last_rec) begin
            errors++;
            $display("FAIL hold cyc=%0d got=%h exp=%h", cyc, rnd_o, last_rec);
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (pend && n < 400) begin
         step();
         n++;
      end
      if (pend) begin
         checks++; errors++;
         $display("FAIL idle_timeout cyc=%0d got=busy exp=idle", cyc);
         pend = 1'b0;
      end
   endtask

   task automatic issue(input fp_div_iter_in_type d);
      fp_rnd_in_type r;
      int lat;
      wait_idle();
      model(d, r, lat);
      div_i = d;
      start = 1'b1;
      exp_rec = r;
      start_cyc = cyc;
      due = cyc + lat;
      pend = 1'b1;
      step();
      start = 1'b0;
      div_i = rand_op();
   endtask

   task automatic pin(input string nm, input fp_div_iter_in_type d,
                      input fp_rnd_in_type want, input int want_lat);
      fp_rnd_in_type r;
      int l;
      model(d, r, l);
      checks++;
      if (r !== want || l != want_lat) begin
         errors++;
         $display("FAIL pin_%s got=%h lat=%0d exp=%h lat=%0d", nm, r, l, want, want_lat);
      end
      issue(d);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      fp_div_iter_in_type d13, d62, dmin;
      reset = 1'b1; start = 1'b0; kill = 1'b0; div_i = '0;
      #12;
      checks += 3;
      if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", valid); end
      if (ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", ready); end
      if (rnd_o !== '0) begin errors++; $display("FAIL rst_rnd got=%h exp=0", rnd_o); end
      @(negedge clock);
      reset = 1'b0;
      step();
      chk_en = 1'b1;

      d13  = mk(0, 1023, 53'h10000000000000, 4'b0, 0, 1024, 53'h18000000000000, 4'b0, 2'd1, 3'd0);
      d62  = mk(0, 129, 53'hC00000, 4'b0, 0, 128, 53'h800000, 4'b0, 2'd0, 3'd1);
      dmin = mk(0, 1, 53'h10000000000000, 4'b0, 0, 1024, 53'h10000000000000, 4'b0, 2'd1, 3'd4);

      pin("one_third", d13, mkr(0, 1021, 54'h15555555555555, 3'b011, 2'b01, 5'b0, 2'd1, 3'd0), 56);
      pin("six_two", d62, mkr(0, 128, 54'hC00000, 3'b000, 2'b00, 5'b0, 2'd0, 3'd1), LAT_62);
      pin("dbz", mk(0, 1023, 53'h10000000000000, 4'b0, 0, 0, 53'h0, 4'b0001, 2'd1, 3'd2),
          mkr(0, 0, '0, 3'b0, 2'b0, 5'b00100, 2'd1, 3'd2), 1);
      pin("zero_zero", mk(0, 0, 53'h0, 4'b0001, 1, 0, 53'h0, 4'b0001, 2'd1, 3'd0),
          mkr(1, 0, '0, 3'b0, 2'b0, 5'b10000, 2'd1, 3'd0), 1);
      pin("minf_two", mk(1, 0, 53'h0, 4'b0010, 0, 1024, 53'h10000000000000, 4'b0, 2'd1, 3'd3),
          mkr(1, 0, '0, 3'b0, 2'b0, 5'b00010, 2'd1, 3'd3), 1);
      pin("min_normal", dmin, mkr(0, 0, 54'h08000000000000, 3'b000, 2'b00, 5'b0, 2'd1, 3'd4), LAT_MIN);

      // kill in DIV at cycle 10: no valid, ready again at cycle 11.
      issue(d13);
      repeat (9) step();
      kill = 1'b1;
      step();
      kill = 1'b0;
      pend = 1'b0;
      repeat (2) step();
      issue(d62);

      // kill together with start in IDLE: start ignored.
      wait_idle();
      div_i = d13; start = 1'b1; kill = 1'b1;
      step();
      start = 1'b0; kill = 1'b0;
      repeat (3) step();

      // kill during DONE is ignored.
      issue(mk(0, 5, 53'h800000, 4'b0, 0, 5, 53'h800000, 4'b0100, 2'd0, 3'd0));
      kill = 1'b1;
      step();
      kill = 1'b0;

      // Asynchronous reset in the middle of DIV.
      issue(d13);
      repeat (20) step();
      #1 reset = 1'b1;
      #1;
      checks += 3;
      if (valid !== 1'b0) begin errors++; $display("FAIL arst_valid got=%b exp=0", valid); end
      if (ready !== 1'b1) begin errors++; $display("FAIL arst_ready got=%b exp=1", ready); end
      if (rnd_o !== '0) begin errors++; $display("FAIL arst_rnd got=%h exp=0", rnd_o); end
      pend = 1'b0;
      last_rec = '0;
      #1 reset = 1'b0;
      step();
      issue(d13);

      for (int i = 0; i < 150; i++) issue(rand_op());

      wait_idle();
      repeat (3) step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
